// File: rtl/idu_decode_queue.sv
// Decode-stage instruction queue: DEPTH-entry circular buffer of {inst, pc}
// between fetch and execute, with RV32I field/immediate decode of the head
// entry and a single-cycle flush for redirects.
module idu_decode_queue #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic [PC_W-1:0]              out_pc,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [2:0]                   out_funct3,
  output logic [XLEN-1:0]              out_imm,
  output logic [2:0]                   out_fmt,
  output logic                         out_rd_wen,
  output logic                         out_mem_ren,
  output logic                         out_mem_wen,
  output logic                         out_branch,
  output logic                         out_jump,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_NONE = 3'd7;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  // in_ready depends only on occupancy (and reset), never on out_ready
  assign in_ready  = rst_n & (count != CW'(DEPTH));
  assign out_valid = (count != '0) & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Queue storage and pointers; flush discards everything incl. this cycle's push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{inst: in_inst, pc: in_pc};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [31:0] imm32;

  assign inst       = mem[rd_ptr].inst;
  assign opc        = inst[6:0];
  assign out_inst   = inst;
  assign out_pc     = mem[rd_ptr].pc;
  assign out_rs1    = inst[19:15];
  assign out_rs2    = inst[24:20];
  assign out_rd     = inst[11:7];
  assign out_funct3 = inst[14:12];
  // Immediates are built at 32 bits then sign-extended to the datapath width
  assign out_imm    = XLEN'($signed(imm32));

  // Head-entry decode: format, immediate and control flags
  always_comb begin
    out_fmt     = F_NONE;
    imm32       = '0;
    out_mem_ren = 1'b0;
    out_mem_wen = 1'b0;
    out_branch  = 1'b0;
    out_jump    = 1'b0;
    case (opc)
      7'b0110111, 7'b0010111: begin
        out_fmt = F_U;
        imm32   = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        out_fmt  = F_J;
        out_jump = 1'b1;
        imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b1100111: begin
        out_fmt  = F_I;
        out_jump = 1'b1;
        imm32    = {{20{inst[31]}}, inst[31:20]};
      end
      7'b1100011: begin
        out_fmt    = F_B;
        out_branch = 1'b1;
        imm32      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0000011: begin
        out_fmt     = F_I;
        out_mem_ren = 1'b1;
        imm32       = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        out_fmt     = F_S;
        out_mem_wen = 1'b1;
        imm32       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b0010011: begin
        out_fmt = F_I;
        // shifts carry an unsigned shamt, not a signed immediate
        if (inst[13:12] == 2'b01) imm32 = {27'b0, inst[24:20]};
        else                      imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0110011: out_fmt = F_R;
      OP_SYS: begin
        out_fmt = F_I;
        imm32   = {{20{inst[31]}}, inst[31:20]};
      end
      default: ;
    endcase
    out_illegal = (out_fmt == F_NONE);
    // ecall/ebreak/mret (funct3==0) never write a register
    out_rd_wen  = ~out_illegal & (inst[11:7] != 5'd0) &
                  (out_fmt inside {F_R, F_I, F_U, F_J}) &
                  ~((opc == OP_SYS) & (inst[14:12] == 3'b000));
  end
endmodule

// File: tb/tb_idu_decode_queue.sv
// Bench for idu_decode_queue: queue-based reference model plus directed vectors.
module tb_idu_decode_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst = 0, in_pc = 0;
  logic        in_ready, out_valid;
  logic [31:0] out_inst, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3, out_fmt;
  logic        out_rd_wen, out_mem_ren, out_mem_wen, out_branch, out_jump, out_illegal;
  logic [CW-1:0] count;

  idu_decode_queue #(.XLEN(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_rd_wen(out_rd_wen),
    .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen), .out_branch(out_branch),
    .out_jump(out_jump), .out_illegal(out_illegal), .count(count));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [5:0]  flg; // {rd_wen, mem_ren, mem_wen, branch, jump, illegal}
  } dec_t;

  ent_t mq[$];

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    int   v;
    logic [12:0] boff;
    logic [20:0] joff;
    logic [11:0] sv;
    logic ren, wen, br, jp;
    ren = 0; wen = 0; br = 0; jp = 0;
    d.fmt = 7; d.imm = 0; v = 0;
    case (w[6:0])
      7'h37, 7'h17: begin d.fmt = 4; v = int'(w) & 32'hFFFFF000; end
      7'h6F: begin d.fmt = 5; jp = 1;
        joff = {w[31], w[19:12], w[20], w[30:21], 1'b0}; v = $signed(joff); end
      7'h67: begin d.fmt = 1; jp = 1; v = $signed(w[31:20]); end
      7'h63: begin d.fmt = 3; br = 1;
        boff = {w[31], w[7], w[30:25], w[11:8], 1'b0}; v = $signed(boff); end
      7'h03: begin d.fmt = 1; ren = 1; v = $signed(w[31:20]); end
      7'h23: begin d.fmt = 2; wen = 1; sv = {w[31:25], w[11:7]}; v = $signed(sv); end
      7'h13: begin d.fmt = 1;
        if (w[14:12] == 1 || w[14:12] == 5) v = int'(w[24:20]); else v = $signed(w[31:20]); end
      7'h33: d.fmt = 0;
      7'h73: begin d.fmt = 1; v = $signed(w[31:20]); end
      default: ;
    endcase
    d.imm = v;
    d.flg = {1'b0, ren, wen, br, jp, d.fmt == 7};
    if (d.fmt != 7 && d.fmt != 2 && d.fmt != 3 && w[11:7] != 0 &&
        !(w[6:0] == 7'h73 && w[14:12] == 0))
      d.flg[5] = 1;
    return d;
  endfunction

  // Model state advances on the same edge as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else if (flush) mq.delete();
    else begin
      bit pu, po;
      pu = in_valid && (mq.size() < DEPTH);
      po = (mq.size() != 0) && out_ready;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back('{inst: in_inst, pc: in_pc});
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic ev;
    dec_t d;
    ev = (mq.size() != 0) && !flush;
    chk("in_ready", in_ready, rst_n && mq.size() != DEPTH);
    chk("out_valid", out_valid, ev);
    chk("count", count, mq.size());
    if (ev) begin
      d = ref_decode(mq[0].inst);
      chk("m_inst", out_inst, mq[0].inst);
      chk("m_pc", out_pc, mq[0].pc);
      chk("m_regs", {out_rs1, out_rs2, out_rd, out_funct3},
          {mq[0].inst[19:15], mq[0].inst[24:20], mq[0].inst[11:7], mq[0].inst[14:12]});
      chk("m_imm", out_imm, d.imm);
      chk("m_fmt", out_fmt, d.fmt);
      chk("m_flags", {out_rd_wen, out_mem_ren, out_mem_wen, out_branch, out_jump, out_illegal}, d.flg);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] words [12] = '{32'h00112623, 32'h00C12083, 32'h008000EF, 32'h000080E7,
                              32'h00000517, 32'h002081B3, 32'h00000073, 32'h340112F3,
                              32'h00309093, 32'h0000000F, 32'h00000013, 32'hFEA12E23};

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic push1(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1; in_inst = w; in_pc = pc; tick(); in_valid = 0;
  endtask

  task automatic pop1(); out_ready = 1; tick(); out_ready = 0; endtask

  task automatic fill_drain(input int base);
    out_ready = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1; in_inst = words[(base + i) % 12]; in_pc = 32'h1000 + 4 * (base + i); tick();
    end
    in_valid = 0;
    @(negedge clk);
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_inst, words[base % 12]);
    out_ready = 1;
    repeat (DEPTH) tick();
    out_ready = 0;
    @(negedge clk);
    chk("drained", count, 0);
  endtask

  initial begin
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_dec", {out_illegal, out_fmt, out_rd_wen, out_mem_ren, out_mem_wen, out_branch, out_jump},
        {1'b1, 3'd7, 5'b0});
    chk("rst_fields", {out_imm, out_pc, out_rs1, out_rs2, out_rd}, 0);
    tick(); tick();
    rst_n = 1;

    // addi x1,x0,-1
    push1(32'hFFF00093, 32'h80000000);
    @(negedge clk);
    chk("addi_valid", out_valid, 1);
    chk("addi_fmt", out_fmt, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_rdwen", out_rd_wen, 1);
    chk("addi_pc", out_pc, 32'h80000000);
    pop1();

    // beq / lui / srai in order
    push1(32'hFE000EE3, 32'h100);
    push1(32'h123452B7, 32'h104);
    push1(32'h4071D193, 32'h108);
    @(negedge clk);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_br", {out_branch, out_rd_wen}, 2'b10);
    pop1(); @(negedge clk);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_fmt_rd", {out_fmt, out_rd}, {3'd4, 5'd5});
    pop1(); @(negedge clk);
    chk("srai_imm", out_imm, 32'h7);
    chk("srai_fmt", out_fmt, 1);
    pop1();

    // full / back-pressure, then offset pointers and fill again to wrap
    fill_drain(0);
    push1(words[6], 32'h2000); pop1();
    fill_drain(5);

    // simultaneous push and pop at count==2
    push1(words[8], 32'h3000);
    push1(words[9], 32'h3004);
    in_valid = 1; in_inst = words[10]; in_pc = 32'h3008; out_ready = 1; tick();
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("pp_count", count, 2);
    chk("pp_head", out_inst, words[9]);
    pop1(); pop1();

    // flush at count==3 with push and pop in the same cycle
    push1(words[0], 32'h4000); push1(words[1], 32'h4004); push1(words[2], 32'h4008);
    flush = 1; in_valid = 1; in_inst = words[3]; in_pc = 32'h400C; out_ready = 1;
    @(negedge clk);
    chk("fl_valid_during", out_valid, 0);
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("fl_count", count, 0);
    chk("fl_valid_after", out_valid, 0);
    push1(words[4], 32'h5000);
    @(negedge clk);
    chk("fl_next", {out_valid, count, out_inst}, {1'b1, CW'(1), words[4]});
    pop1();

    // illegal encodings
    push1(32'h00000000, 32'h6000);
    push1(32'hFFFFFFFF, 32'h6004);
    @(negedge clk);
    chk("ill0", {out_illegal, out_fmt, out_rd_wen, out_mem_ren, out_mem_wen, out_branch, out_jump, out_imm},
        {1'b1, 3'd7, 5'b0, 32'h0});
    pop1(); @(negedge clk);
    chk("ill1", {out_illegal, out_fmt, out_rd_wen, out_mem_ren, out_mem_wen, out_branch, out_jump, out_imm},
        {1'b1, 3'd7, 5'b0, 32'h0});
    pop1();

    // reset mid-operation drops contents immediately
    push1(words[0], 32'h7000); push1(words[1], 32'h7004);
    rst_n = 0; #1;
    chk("mrst_count", count, 0);
    chk("mrst_valid", {out_valid, in_ready}, 2'b00);
    #1 rst_n = 1;
    push1(words[2], 32'h8000);
    @(negedge clk);
    chk("mrst_next", {count, out_inst}, {CW'(1), words[2]});
    pop1();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idu_decode_queue.md
# idu_decode_queue

Parametrised decode-stage front end: a DEPTH-entry instruction queue between fetch and execute that buffers `{inst, pc}` pairs under valid/ready handshakes, decodes the head entry into RV32I fields with correctly sign-extended immediates, and supports a single-cycle pipeline flush. It replaces the single-register decode latch, decoupling fetch stalls from execute back-pressure and adding illegal-instruction detection.

## Interface
- XLEN, 32, immediate/datapath width (≥32)
- PC_W, 32, program-counter width
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all queued entries (branch/trap redirect)
- in_valid  in  1  fetch offers `{in_inst, in_pc}`
- in_ready  out  1  queue can accept
- in_inst  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- out_inst  out  32  head instruction
- out_pc  out  PC_W  head pc
- out_rs1 / out_rs2 / out_rd  out  5 each  inst[19:15] / [24:20] / [11:7]
- out_funct3  out  3  inst[14:12]
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 none/illegal
- out_rd_wen, out_mem_ren, out_mem_wen, out_branch, out_jump, out_illegal  out  1 each  decode flags
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, plus count register.
- Push when in_valid & in_ready; pop when out_valid & out_ready; both in one cycle: count unchanged, both pointers advance.
- in_ready = rst_n & (count != DEPTH); no combinational path from out_ready.
- out_valid = (count != 0) & ~flush.
- Flush: next edge sets wr_ptr=rd_ptr=0, count=0; any push or pop in the flush cycle is discarded. Flush wins over every other event.
- Decode is combinational from the head entry only.
- Opcode map: 0110111/0010111 → U; 1101111 → J, jump; 1100111 → I, jump; 1100011 → B, branch; 0000011 → I, mem_ren; 0100011 → S, mem_wen; 0010011 → I; 0110011 → R; 1110011 → I.
- Any other opcode, or inst[1:0] != 2'b11 → out_illegal=1, fmt=7, all other flags 0, imm=0.
- Immediates sign-extended from inst[31] to XLEN: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}; R → 0.
- Exception: OP-IMM with funct3 001/101 → imm = zero-extended inst[24:20].
- out_rd_wen = (fmt ∈ {R,I,U,J}) & (rd != 0) & ~illegal; for SYSTEM only when funct3 != 0; for ecall/mret rd_wen = 0.

## Timing
- Reset (async): pointers, count and all storage to 0 → out_valid=0, in_ready=0 while rst_n low, count=0. Outputs then show the decode of 32'h0: out_illegal=1, fmt=7, all other flags 0, imm=0, rs/rd/pc=0.
- First edge after release: in_ready=1.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N; there is no same-cycle bypass.
- Throughput: 1/cycle sustained when out_ready is held high.
- Full (count==DEPTH): in_ready=0. A pop that cycle frees a slot, and in_ready rises after the edge.
- Empty: out_valid=0; head fields hold stale data and must be ignored.
- Reset mid-operation: all contents are lost immediately; no partial-entry state survives.
- Holding: head outputs stay stable while out_valid & ~out_ready.

## Test plan
- Reset, then push 0xFFF00093 (addi x1,x0,-1) at pc 0x80000000 → one cycle later out_valid=1, fmt=1, rd=1, imm=0xFFFFFFFF, rd_wen=1, out_pc=0x80000000.
- Push 0xFE000EE3 (beq x0,x0,-4), 0x123452B7 (lui x5,0x12345), 0x4071D193 (srai x3,x3,7) → in order: imm 0xFFFFFFFC/branch=1/rd_wen=0; imm 0x12345000/fmt=4/rd=5; imm 0x00000007/fmt=1.
- out_ready=0, push DEPTH+2 words → count=DEPTH, in_ready=0, exactly DEPTH accepted. Release out_ready → first DEPTH words drain in order; pointer wrap is verified by a second fill/drain.
- Push and pop in the same cycle at count=2 → count stays 2; ordering preserved.
- Assert flush at count=3 with a simultaneous push and pop → next cycle count=0, out_valid=0 during and after; the next push is the only entry out.
- Push 0x00000000 and 0xFFFFFFFF → out_illegal=1, fmt=7, all flags 0.
